// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_pkg
//  Purpose  : Shared segment type and segment-pattern constants for the
//             seven-segment time display. Patterns are active-low
//             {g,f,e,d,c,b,a}, bit 0 = segment a.
//  Contents : seg7_t, SEG_BLANK, SEG_DASH, SEG_ALL_ON, SEG_0..SEG_9
//  Revision : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK  = 7'h7F;   // all segments off
    localparam seg7_t SEG_DASH   = 7'h3F;   // segment g only
    localparam seg7_t SEG_ALL_ON = 7'h00;   // all segments lit

    localparam seg7_t SEG_0 = 7'h40;
    localparam seg7_t SEG_1 = 7'h79;
    localparam seg7_t SEG_2 = 7'h24;
    localparam seg7_t SEG_3 = 7'h30;
    localparam seg7_t SEG_4 = 7'h19;
    localparam seg7_t SEG_5 = 7'h12;
    localparam seg7_t SEG_6 = 7'h02;
    localparam seg7_t SEG_7 = 7'h78;
    localparam seg7_t SEG_8 = 7'h00;
    localparam seg7_t SEG_9 = 7'h10;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD digit to active-low seven-segment decode.
//             Codes 10..15 produce a dash so a corrupt digit is visible but
//             never undefined.
//  Ports    : bcd_i  [3:0]  BCD digit
//             seg_o  [6:0]  active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seven_seg_time_display.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_time_display
//  Purpose  : Drives eight active-low seven-segment displays from the BCD
//             time digits. Each digit is decoded and registered (1-cycle
//             latency). A blink timer blanks the field (sec/min/hr) that is
//             currently being set; an adjust pulse restarts the blink in its
//             visible phase so an edited value shows at once.
//  Ports    : clk_i, nreset_i (async, active low)
//             centisec_i..decahr_i [3:0]   BCD digits (hex0..hex7)
//             blink_sec_i/min_i/hr_i       field-being-set flags
//             hold_visible_i               restart blink in visible phase
//             hex0_o..hex7_o [6:0]         active-low segments
//             lamp_test_i                  only with SEVEN_SEG_LAMP_TEST_EN
//  Config   : `define SEVEN_SEG_LAMP_TEST_EN adds the lamp-test input which
//             forces every segment on while held.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_time_display
    import seven_seg_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 25
)(
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic [3:0] centisec_i,
    input  logic [3:0] decisec_i,
    input  logic [3:0] sec_i,
    input  logic [3:0] decasec_i,
    input  logic [3:0] min_i,
    input  logic [3:0] decamin_i,
    input  logic [3:0] hr_i,
    input  logic [3:0] decahr_i,
    input  logic       blink_sec_i,
    input  logic       blink_min_i,
    input  logic       blink_hr_i,
    input  logic       hold_visible_i,
`ifdef SEVEN_SEG_LAMP_TEST_EN
    input  logic       lamp_test_i,
`endif
    output logic [6:0] hex0_o,
    output logic [6:0] hex1_o,
    output logic [6:0] hex2_o,
    output logic [6:0] hex3_o,
    output logic [6:0] hex4_o,
    output logic [6:0] hex5_o,
    output logic [6:0] hex6_o,
    output logic [6:0] hex7_o
);

    localparam int CNT_W = $clog2(BLINK_HALF_PERIOD);
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(BLINK_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Blink timer
    // ------------------------------------------------------------------
    logic             w_blink_any;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;   // 1 = visible, 0 = blanked

    assign w_blink_any = blink_sec_i | blink_min_i | blink_hr_i;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!w_blink_any) begin
            // Nothing being set: park the timer at the start of a visible phase.
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (hold_visible_i) begin
            // Adjust pulse wins over the terminal-count toggle.
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == C_TERM) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-digit decode
    // ------------------------------------------------------------------
    logic [3:0] w_bcd [8];
    seg7_t      w_seg [8];
    logic [7:0] w_field_blink;

    assign w_bcd[0] = centisec_i;
    assign w_bcd[1] = decisec_i;
    assign w_bcd[2] = sec_i;
    assign w_bcd[3] = decasec_i;
    assign w_bcd[4] = min_i;
    assign w_bcd[5] = decamin_i;
    assign w_bcd[6] = hr_i;
    assign w_bcd[7] = decahr_i;

    // Which blink flag owns each digit; hex0/hex1 belong to no field.
    assign w_field_blink = {blink_hr_i,  blink_hr_i,
                            blink_min_i, blink_min_i,
                            blink_sec_i, blink_sec_i,
                            1'b0,        1'b0};

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        bcd_to_seg7 u_dec (
            .bcd_i (w_bcd[gi]),
            .seg_o (w_seg[gi])
        );
    end

    // ------------------------------------------------------------------
    // Blank / lamp-test muxing and output registers
    // ------------------------------------------------------------------
    seg7_t hex_d [8];
    seg7_t hex_q [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hex_d[i] = w_seg[i];
            if (w_field_blink[i] && !phase_q) begin
                hex_d[i] = SEG_BLANK;
            end
`ifdef SEVEN_SEG_LAMP_TEST_EN
            if (lamp_test_i) begin
                hex_d[i] = SEG_ALL_ON;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < 8; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign hex0_o = hex_q[0];
    assign hex1_o = hex_q[1];
    assign hex2_o = hex_q[2];
    assign hex3_o = hex_q[3];
    assign hex4_o = hex_q[4];
    assign hex5_o = hex_q[5];
    assign hex6_o = hex_q[6];
    assign hex7_o = hex_q[7];

endmodule : seven_seg_time_display
`default_nettype wire

// File: tb/tb_seven_seg_time_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_time_display
//  Purpose  : Self-checking bench for seven_seg_time_display: decode table,
//             hand-written blink/hold/flag-switch/reset sequences, and a
//             randomized run against a behavioural model in which the blink
//             phase is derived from the number of counting edges since the
//             last restart.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_time_display;

    localparam int H = 25;

    typedef struct {
        logic [3:0] bcd;
        logic [6:0] seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] d [8];
    logic       b_sec, b_min, b_hr, hold, lamp;
    logic [6:0] hex [8];

    always #5 clk = ~clk;

    seven_seg_time_display #(.BLINK_HALF_PERIOD(H)) dut (
        .clk_i          (clk),
        .nreset_i       (nreset),
        .centisec_i     (d[0]),
        .decisec_i      (d[1]),
        .sec_i          (d[2]),
        .decasec_i      (d[3]),
        .min_i          (d[4]),
        .decamin_i      (d[5]),
        .hr_i           (d[6]),
        .decahr_i       (d[7]),
        .blink_sec_i    (b_sec),
        .blink_min_i    (b_min),
        .blink_hr_i     (b_hr),
        .hold_visible_i (hold),
`ifdef SEVEN_SEG_LAMP_TEST_EN
        .lamp_test_i    (lamp),
`endif
        .hex0_o         (hex[0]),
        .hex1_o         (hex[1]),
        .hex2_o         (hex[2]),
        .hex3_o         (hex[3]),
        .hex4_o         (hex[4]),
        .hex5_o         (hex[5]),
        .hex6_o         (hex[6]),
        .hex7_o         (hex[7])
    );

    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       vtab [16];
    int         elapsed;      // counting edges since last blink restart
    logic [6:0] exp_hex [8];
    int         edge_n;

    function automatic logic visible();
        return ((elapsed / H) % 2) == 0;
    endfunction

    function automatic logic field_flag(int i);
        case (i / 2)
            1:       return b_sec;
            2:       return b_min;
            3:       return b_hr;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_val(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("%s hex%0d", tag, i), hex[i], exp_hex[i]);
    endtask

    // One clock edge; model computes what the edge registers, then advances.
    task automatic tick();
        for (int i = 0; i < 8; i++) begin
            if (lamp)                           exp_hex[i] = 7'h00;
            else if (field_flag(i) && !visible()) exp_hex[i] = 7'h7F;
            else                                exp_hex[i] = vtab[d[i]].seg;
        end
        @(posedge clk);
        #1;
        if (!(b_sec | b_min | b_hr) || hold) elapsed = 0;
        else                                 elapsed++;
        edge_n++;
    endtask

    task automatic model_reset();
        elapsed = 0;
        for (int i = 0; i < 8; i++) exp_hex[i] = 7'h7F;
    endtask

    task automatic set_digits();
        d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd5; d[3] = 4'd4;
        d[4] = 4'd6; d[5] = 4'd7; d[6] = 4'd8; d[7] = 4'd1;
    endtask

    // Flags off for one edge so the timer is parked; edge_n counts from here.
    task automatic prep();
        b_sec = 0; b_min = 0; b_hr = 0; hold = 0; lamp = 0;
        set_digits();
        tick();
        edge_n = 0;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    initial begin
        vtab[0]  = '{4'd0,  7'h40}; vtab[1]  = '{4'd1,  7'h79};
        vtab[2]  = '{4'd2,  7'h24}; vtab[3]  = '{4'd3,  7'h30};
        vtab[4]  = '{4'd4,  7'h19}; vtab[5]  = '{4'd5,  7'h12};
        vtab[6]  = '{4'd6,  7'h02}; vtab[7]  = '{4'd7,  7'h78};
        vtab[8]  = '{4'd8,  7'h00}; vtab[9]  = '{4'd9,  7'h10};
        vtab[10] = '{4'd10, 7'h3F}; vtab[11] = '{4'd11, 7'h3F};
        vtab[12] = '{4'd12, 7'h3F}; vtab[13] = '{4'd13, 7'h3F};
        vtab[14] = '{4'd14, 7'h3F}; vtab[15] = '{4'd15, 7'h3F};

        // ---------------- reset ----------------
        nreset = 0; b_sec = 0; b_min = 0; b_hr = 0; hold = 0; lamp = 0;
        for (int i = 0; i < 8; i++) d[i] = 4'd9;
        model_reset();
        edge_n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) check_val($sformatf("reset hex%0d", i), hex[i], 7'h7F);
        nreset = 1;
        d[0] = 4'd3;
        tick();
        check_val("release hex0", hex[0], 7'h30);
        check_model("release");

        // ---------------- decode table ----------------
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < 8; i++) d[i] = vtab[v].bcd;
            tick();
            for (int i = 0; i < 8; i++)
                check_val($sformatf("decode %0d hex%0d", v, i), hex[i], vtab[v].seg);
        end

        // ---------------- blink sec ----------------
        prep();
        b_sec = 1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1 || k == 25 || k == 26 || k == 50 || k == 51 || k == 60) begin
                check_val($sformatf("blink e%0d hex2", k), hex[2], (k >= 26 && k <= 50) ? 7'h7F : 7'h12);
                check_val($sformatf("blink e%0d hex3", k), hex[3], (k >= 26 && k <= 50) ? 7'h7F : 7'h19);
                check_val($sformatf("blink e%0d hex4", k), hex[4], 7'h02);
                check_val($sformatf("blink e%0d hex7", k), hex[7], 7'h79);
                check_val($sformatf("blink e%0d hex0", k), hex[0], 7'h79);
            end
        end

        // ---------------- hold visible in blanked phase ----------------
        prep();
        b_sec = 1;
        run_to(30);
        check_val("hold pre hex2", hex[2], 7'h7F);
        hold = 1;
        tick();                         // edge 31: still uses blanked phase
        check_val("hold edge hex2", hex[2], 7'h7F);
        hold = 0;
        tick();                         // edge 32
        check_val("hold after hex2", hex[2], 7'h12);
        check_val("hold after hex3", hex[3], 7'h19);
        run_to(56);
        check_val("hold +25 hex2", hex[2], 7'h12);
        tick();                         // edge 57 = hold edge + 26
        check_val("hold +26 hex2", hex[2], 7'h7F);

        // ---------------- hold exactly at terminal count ----------------
        prep();
        b_sec = 1;
        run_to(24);
        hold = 1;
        tick();                         // edge 25: terminal count
        hold = 0;
        tick();
        check_val("tc hold e26 hex2", hex[2], 7'h12);
        run_to(50);
        check_val("tc hold e50 hex2", hex[2], 7'h12);
        tick();
        check_val("tc hold e51 hex2", hex[2], 7'h7F);

        // ---------------- flag switch sec -> min ----------------
        prep();
        b_sec = 1;
        run_to(30);
        b_sec = 0; b_min = 1;
        tick();                         // edge 31
        check_val("switch hex2", hex[2], 7'h12);
        check_val("switch hex3", hex[3], 7'h19);
        check_val("switch hex4", hex[4], 7'h7F);
        check_val("switch hex5", hex[5], 7'h7F);
        run_to(50);
        check_val("switch e50 hex4", hex[4], 7'h7F);
        tick();
        check_val("switch e51 hex4", hex[4], 7'h02);
        run_to(80);
        check_val("switch e80 hex5", hex[5], 7'h7F);
        b_min = 0;
        tick();
        check_val("drop hex4", hex[4], 7'h02);
        check_val("drop hex5", hex[5], 7'h78);

        // ---------------- multiple flags ----------------
        prep();
        b_sec = 1; b_hr = 1;
        run_to(30);
        check_val("multi hex2", hex[2], 7'h7F);
        check_val("multi hex6", hex[6], 7'h7F);
        check_val("multi hex4", hex[4], 7'h02);

`ifdef SEVEN_SEG_LAMP_TEST_EN
        // ---------------- lamp test ----------------
        prep();
        b_sec = 1;
        run_to(30);
        lamp = 1;
        run_to(40);
        for (int i = 0; i < 8; i++) check_val($sformatf("lamp hex%0d", i), hex[i], 7'h00);
        lamp = 0;
        tick();                         // edge 41: still blanked phase
        check_val("lamp rel hex2", hex[2], 7'h7F);
        check_val("lamp rel hex0", hex[0], 7'h79);
        run_to(51);
        check_val("lamp rel e51 hex2", hex[2], 7'h12);
`endif

        // ---------------- reset mid-blink ----------------
        prep();
        b_sec = 1;
        run_to(30);
        #2 nreset = 0;
        model_reset();
        #1;
        for (int i = 0; i < 8; i++) check_val($sformatf("midrst hex%0d", i), hex[i], 7'h7F);
        @(negedge clk);
        nreset = 1;
        tick();
        check_val("midrst rel hex2", hex[2], 7'h12);
        check_model("midrst rel");

        // ---------------- randomized run vs model ----------------
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) d[i] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0: begin b_sec = 0; b_min = 0; b_hr = 0; end
                    1: begin b_sec = 1; b_min = 0; b_hr = 0; end
                    2: begin b_sec = 0; b_min = 1; b_hr = 0; end
                    3: begin b_sec = 0; b_min = 0; b_hr = 1; end
                    default: begin
                        b_sec = 1'($urandom); b_min = 1'($urandom); b_hr = 1'($urandom);
                    end
                endcase
            end
            hold = ($urandom_range(0, 29) == 0);
`ifdef SEVEN_SEG_LAMP_TEST_EN
            if ($urandom_range(0, 49) == 0) lamp = ~lamp;
`endif
            tick();
            check_model($sformatf("rand c%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_seven_seg_time_display
`default_nettype wire

// File: doc/seven_seg_time_display.md
Name: seven_seg_time_display

Overview:
- Downstream stage of the clock/time-keeping block: consumes its eight BCD digit outputs and three blink flags; drives eight active-low seven-segment displays (HEX0..HEX7) on the board.
- Registered per-digit BCD-to-segment decode, plus a blink timer that blanks the field currently being set.
- Blink phase restarts to visible on user adjust pulses, so an edited value is shown immediately.

Parameters:
- BLINK_HALF_PERIOD, 25, clk_i cycles per blink half-period (0.25 s at 100 Hz clk_i); legal range >= 2.
- CNT_W, $clog2(BLINK_HALF_PERIOD), blink counter width (derived localparam, not overridable).

Ports:
- clk_i  in  1  system clock, same clock as the time counters.
- nreset_i  in  1  asynchronous active-low reset.
- centisec_i, decisec_i, sec_i, decasec_i, min_i, decamin_i, hr_i, decahr_i  in  4 each  BCD digits.
- blink_sec_i, blink_min_i, blink_hr_i  in  1 each  field-being-set flags (at most one high).
- hold_visible_i  in  1  pulse; up/down pressed, restart blink in visible phase.
- hex0_o..hex7_o  out  7 each  active-low segments {g,f,e,d,c,b,a}, bit0 = a.
- Digit mapping: hex0=centisec, hex1=decisec, hex2=sec, hex3=decasec, hex4=min, hex5=decamin, hex6=hr, hex7=decahr.

Behaviour:
- Reset (async, nreset_i=0):
  - all hex*_o = 7'h7F (all segments off);
  - blink counter = 0;
  - phase = 1 (visible).
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Invalid BCD 10-15 decodes to dash 7'h3F (g only); never X.
- Latency: outputs registered; inputs sampled at edge N appear on hex*_o after edge N (1 cycle).
- blink_any = blink_sec_i | blink_min_i | blink_hr_i.
- Blink timer:
  - blink_any=0: counter forced 0, phase forced 1.
  - blink_any=1: counter increments each cycle. At counter == BLINK_HALF_PERIOD-1, counter -> 0 and phase toggles.
  - hold_visible_i=1 with blink_any=1: next edge counter -> 0, phase -> 1. This takes priority over terminal-count toggle.
  - hold_visible_i ignored when blink_any=0 (already held).
- Blanking:
  - Field digits output 7'h7F when their blink flag = 1 and phase = 0.
  - Fields: sec = hex2/hex3, min = hex4/hex5, hr = hex6/hex7.
  - hex0/hex1 never blank.
- Flag switching (e.g. sec->min in one cycle): counter and phase continue; the new field blinks in the current phase.
- Multiple blink flags high (illegal upstream): each flagged field blanks per phase; no error.
- Reset mid-blink: immediate blank-all-off; after release, first edge shows decoded digits in visible phase.

Optional Feature:
- Macro SEVEN_SEG_LAMP_TEST_EN.
- Defined:
  - adds port lamp_test_i (in, 1);
  - while 1, all hex*_o register 7'h00 (all segments lit) next edge, overriding decode, dash and blanking;
  - blink timer keeps running unaffected;
  - on deassert, normal output next edge.
- Undefined: port absent; no lamp-test logic.

Decomposition:
- Shared package seven_seg_pkg:
  - SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F, SEG_ALL_ON = 7'h00;
  - the 0-9 segment constants;
  - function/typedef seg7_t (logic [6:0]).
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out, dash on invalid), instantiated 8x.
- Top holds blink timer, blank muxing and output registers.

Test Plan:
- Reset: nreset_i=0 with digits=9 -> all hex*_o=7F. Release with centisec_i=3 -> hex0_o=30 one edge later.
- Decode sweep: each digit input 0..15 -> 0..9 codes as listed; 10..15 -> 3F on every hex output.
- Blink: blink_sec_i held high from edge 0, digits 5/4 -> hex2/hex3 = 12/19 through edge 25, then 7F/7F from edge 26 to 50, then visible again. hex4..hex7 never blank.
- Hold visible: during blanked phase pulse hold_visible_i one cycle -> hex2/hex3 visible after next edge; blank again 25 cycles later. Pulse exactly at terminal count -> stays visible.
- Flag switch: blink_sec_i->blink_min_i mid-blanked phase -> hex2/hex3 visible next edge, hex4/hex5 blank, phase timing unbroken. Drop all flags -> everything visible next edge.
- Lamp test (macro defined): lamp_test_i=1 during blanked phase -> all hex*_o=00. Release -> resumes with blink phase advanced by elapsed cycles.
